// File: rtl/poc_ctrl_pkg.sv
// Shared definitions for the Poc control unit: opcodes, mux/ALU select codes,
// FSM state encoding and the legal DRAM read-wait range.
package poc_ctrl_pkg;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_LDI   = 5'h01;
  localparam logic [4:0] OP_MOVA  = 5'h02;
  localparam logic [4:0] OP_MOVR  = 5'h03;
  localparam logic [4:0] OP_ADD   = 5'h04;
  localparam logic [4:0] OP_SUB   = 5'h05;
  localparam logic [4:0] OP_INC   = 5'h06;
  localparam logic [4:0] OP_SHR   = 5'h07;
  localparam logic [4:0] OP_LOAD  = 5'h08;
  localparam logic [4:0] OP_STORE = 5'h09;
  localparam logic [4:0] OP_JMP   = 5'h0A;
  localparam logic [4:0] OP_JMPN  = 5'h0B;
  localparam logic [4:0] OP_JMPL  = 5'h0C;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  localparam logic [3:0] MUXA_IDR      = 4'd0;
  localparam logic [3:0] MUXA_MDR      = 4'd1;
  localparam logic [3:0] MUXA_RADDRESS = 4'd7;

  localparam logic [1:0] MUXB_TR = 2'd0;
  localparam logic [1:0] MUXB_AC = 2'd1;

  localparam logic [3:0] ALU_PASSA = 4'd0;
  localparam logic [3:0] ALU_PASSB = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_INC   = 4'd4;
  localparam logic [3:0] ALU_SHR   = 4'd5;

  localparam int DRAM_RD_WAIT_MIN = 1;
  localparam int DRAM_RD_WAIT_MAX = 3;

  typedef enum logic [4:0] {
    ST_IDLE, ST_STEP_WAIT, ST_F1, ST_F2, ST_F3, ST_DEC, ST_O1, ST_O2, ST_EXEC,
    ST_L1, ST_LW, ST_L2, ST_L3, ST_S1, ST_S2, ST_S3, ST_HALT
  } state_e;

endpackage

// File: rtl/poc_ctrl_if.sv
// Control/status bundle between the Poc control unit (master) and the Poc datapath (slave).
interface poc_ctrl_if;
  logic [8:0] dout_ir;
  logic       lsb, neg;
  logic       inc_pc, write_pc, write_iar, inc_iar, write_idr, write_ir, write_tr;
  logic       write_dram, off_dram, write_mar, write1_mdr, write2_mdr, write_ac;
  logic       write_rcol, write_rrow, write_ri, write_rj;
  logic       write_rtotal, write_raddress, write_rbnd, write_rcoltemp;
  logic [3:0] select_mux_a;
  logic [1:0] select_mux_b;
  logic [3:0] alu_sel;

  modport master (
    input  dout_ir, lsb, neg,
    output inc_pc, write_pc, write_iar, inc_iar, write_idr, write_ir, write_tr,
    output write_dram, off_dram, write_mar, write1_mdr, write2_mdr, write_ac,
    output write_rcol, write_rrow, write_ri, write_rj,
    output write_rtotal, write_raddress, write_rbnd, write_rcoltemp,
    output select_mux_a, select_mux_b, alu_sel
  );

  modport slave (
    output dout_ir, lsb, neg,
    input  inc_pc, write_pc, write_iar, inc_iar, write_idr, write_ir, write_tr,
    input  write_dram, off_dram, write_mar, write1_mdr, write2_mdr, write_ac,
    input  write_rcol, write_rrow, write_ri, write_rj,
    input  write_rtotal, write_raddress, write_rbnd, write_rcoltemp,
    input  select_mux_a, select_mux_b, alu_sel
  );
endinterface

// File: rtl/poc_ctrl_regdec.sv
// Register-field decoder: maps mux A code 2..9 to one-hot R write enables and
// flags whether the field is a legal read (0..9) or write (2..9) operand.
module poc_ctrl_regdec (
  input  logic [3:0] reg_field,
  output logic [7:0] wr_en_oh,
  output logic       valid_wr,
  output logic       valid_rd
);

  always_comb begin
    wr_en_oh = '0;
    valid_rd = (reg_field <= 4'd9);
    valid_wr = (reg_field >= 4'd2) && (reg_field <= 4'd9);
    if (valid_wr) wr_en_oh[3'(reg_field - 4'd2)] = 1'b1;
  end

endmodule

// File: rtl/poc_control_unit.sv
// Poc sequencing FSM: fetch, decode, execute until HALT.
// Optional POC_CTRL_STEP_EN adds a step input that gates each instruction.
module poc_control_unit
  import poc_ctrl_pkg::*;
#(
  parameter int DRAM_RD_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef POC_CTRL_STEP_EN
  input  logic       step,
`endif
  poc_ctrl_if.master dp,
  output logic       done,
  output logic       illegal
);

`ifdef POC_CTRL_STEP_EN
  localparam state_e INSTR_END = ST_STEP_WAIT;
`else
  localparam state_e INSTR_END = ST_F1;
`endif
  localparam logic [1:0] WAIT_LOAD = 2'(DRAM_RD_WAIT - 1);

  state_e     state_q, state_d;
  logic [8:0] ir_q, ir_d;
  logic [1:0] wait_q, wait_d;
  logic       done_q, done_d, illegal_q, illegal_d;
  logic       bad_instr, r_wr;
  logic [3:0] reg_field;
  logic [7:0] r_oh, r_we;
  logic       valid_wr, valid_rd;

  // DEC checks the live IR; every later state works from the captured copy.
  assign reg_field = (state_q == ST_DEC) ? dp.dout_ir[3:0] : ir_q[3:0];

  poc_ctrl_regdec u_regdec (
    .reg_field (reg_field),
    .wr_en_oh  (r_oh),
    .valid_wr  (valid_wr),
    .valid_rd  (valid_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    bad_instr = 1'b0;
    case (state_q)
      ST_IDLE:      if (start) state_d = INSTR_END;
`ifdef POC_CTRL_STEP_EN
      ST_STEP_WAIT: if (step) state_d = ST_F1;
`else
      ST_STEP_WAIT: state_d = ST_F1;
`endif
      ST_F1:        state_d = ST_F2;
      ST_F2:        state_d = ST_F3;
      ST_F3:        state_d = ST_DEC;
      ST_DEC: begin
        ir_d = dp.dout_ir;
        case (dp.dout_ir[8:4])
          OP_NOP:                            state_d = INSTR_END;
          OP_LDI, OP_JMP, OP_JMPN, OP_JMPL:  state_d = ST_O1;
          OP_MOVA, OP_ADD, OP_SUB, OP_SHR:   if (valid_rd) state_d = ST_EXEC; else bad_instr = 1'b1;
          OP_MOVR, OP_INC:                   if (valid_wr) state_d = ST_EXEC; else bad_instr = 1'b1;
          OP_LOAD:                           state_d = ST_L1;
          OP_STORE:                          state_d = ST_S1;
          OP_HALT:                           state_d = ST_HALT;
          default:                           bad_instr = 1'b1;
        endcase
        if (bad_instr) state_d = ST_HALT;
      end
      ST_O1:        state_d = ST_O2;
      ST_O2:        state_d = ST_EXEC;
      ST_EXEC:      state_d = INSTR_END;
      ST_L1: begin
        wait_d  = WAIT_LOAD;
        state_d = ST_LW;
      end
      ST_LW:        if (wait_q == 2'd0) state_d = ST_L2; else wait_d = wait_q - 2'd1;
      ST_L2:        state_d = ST_L3;
      ST_L3:        state_d = INSTR_END;
      ST_S1:        state_d = ST_S2;
      ST_S2:        state_d = ST_S3;
      ST_S3:        state_d = INSTR_END;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
    done_d    = done_q | (state_d == ST_HALT);
    illegal_d = illegal_q | bad_instr;
  end

  always_comb begin
    dp.inc_pc       = 1'b0;
    dp.write_pc     = 1'b0;
    dp.write_iar    = 1'b0;
    dp.inc_iar      = 1'b0;
    dp.write_idr    = 1'b0;
    dp.write_ir     = 1'b0;
    dp.write_tr     = 1'b0;
    dp.write_dram   = 1'b0;
    dp.off_dram     = 1'b1;
    dp.write_mar    = 1'b0;
    dp.write1_mdr   = 1'b0;
    dp.write2_mdr   = 1'b0;
    dp.write_ac     = 1'b0;
    dp.select_mux_a = MUXA_IDR;
    dp.select_mux_b = MUXB_TR;
    dp.alu_sel      = ALU_PASSA;
    r_wr            = 1'b0;
    case (state_q)
      ST_F1, ST_O1: dp.write_iar = 1'b1;
      ST_F2:        dp.write_idr = 1'b1;
      ST_F3: begin
        dp.write_ir = 1'b1;
        dp.inc_pc   = 1'b1;
      end
      ST_O2: begin
        dp.write_idr = 1'b1;
        dp.inc_pc    = 1'b1;
      end
      ST_EXEC: begin
        case (ir_q[8:4])
          OP_LDI:  dp.write_ac = 1'b1;
          OP_MOVA: begin dp.select_mux_a = ir_q[3:0]; dp.write_ac = 1'b1; end
          OP_MOVR: begin dp.select_mux_b = MUXB_AC; dp.alu_sel = ALU_PASSB; r_wr = 1'b1; end
          OP_ADD:  begin dp.select_mux_a = ir_q[3:0]; dp.select_mux_b = MUXB_AC; dp.alu_sel = ALU_ADD; dp.write_ac = 1'b1; end
          OP_SUB:  begin dp.select_mux_a = ir_q[3:0]; dp.select_mux_b = MUXB_AC; dp.alu_sel = ALU_SUB; dp.write_ac = 1'b1; end
          OP_INC:  begin dp.select_mux_a = ir_q[3:0]; dp.alu_sel = ALU_INC; r_wr = 1'b1; end
          OP_SHR:  begin dp.select_mux_a = ir_q[3:0]; dp.alu_sel = ALU_SHR; dp.write_ac = 1'b1; end
          OP_JMP:  dp.write_pc = 1'b1;
          OP_JMPN: dp.write_pc = dp.neg;
          OP_JMPL: dp.write_pc = dp.lsb;
          default: ;
        endcase
      end
      ST_L1: begin
        dp.select_mux_a = MUXA_RADDRESS;
        dp.write_mar    = 1'b1;
        dp.off_dram     = 1'b0;
      end
      ST_LW:        dp.off_dram = 1'b0;
      ST_L2: begin
        dp.write1_mdr = 1'b1;
        dp.off_dram   = 1'b0;
      end
      ST_L3: begin
        dp.select_mux_a = MUXA_MDR;
        dp.write_ac     = 1'b1;
      end
      ST_S1: begin
        dp.select_mux_b = MUXB_AC;
        dp.alu_sel      = ALU_PASSB;
        dp.write2_mdr   = 1'b1;
      end
      ST_S2: begin
        dp.select_mux_a = MUXA_RADDRESS;
        dp.write_mar    = 1'b1;
      end
      ST_S3: begin
        dp.write_dram = 1'b1;
        dp.off_dram   = 1'b0;
      end
      default: ;
    endcase
    r_we = r_wr ? r_oh : 8'h00;
    {dp.write_rcoltemp, dp.write_rbnd, dp.write_raddress, dp.write_rtotal,
     dp.write_rj, dp.write_ri, dp.write_rrow, dp.write_rcol} = r_we;
  end

  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_poc_control_unit.sv
// Directed bench for poc_control_unit: a small Poc datapath model runs short programs,
// plus a second instance with DRAM_RD_WAIT=2 fed a constant LOAD to check read timing.
module tb_poc_control_unit;
  import poc_ctrl_pkg::*;

`ifdef POC_CTRL_STEP_EN
  localparam int STEP_EXTRA = 1;
`else
  localparam int STEP_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, step;
  logic done, illegal, done2, illegal2;
  always #5 clk = ~clk;

  poc_ctrl_if dpi ();
  poc_ctrl_if dpi2 ();

  poc_control_unit #(.DRAM_RD_WAIT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef POC_CTRL_STEP_EN
    .step(step),
`endif
    .dp(dpi), .done(done), .illegal(illegal)
  );

  poc_control_unit #(.DRAM_RD_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
`ifdef POC_CTRL_STEP_EN
    .step(step),
`endif
    .dp(dpi2), .done(done2), .illegal(illegal2)
  );

  // datapath model
  logic [8:0] iram [512];
  logic [8:0] dram_init [512];
  logic [8:0] dram [512];
  logic [8:0] rr [16];
  logic [8:0] pc, iar, idr, ir, ac, mar, mdr;
  logic       neg_m, lsb_m;
  logic [8:0] a_v, b_v, res_v;

  assign dpi.dout_ir  = ir;
  assign dpi.lsb      = lsb_m;
  assign dpi.neg      = neg_m;
  assign dpi2.dout_ir = 9'h080;
  assign dpi2.lsb     = 1'b0;
  assign dpi2.neg     = 1'b0;

  function automatic logic [8:0] alu_fn(input logic [3:0] sel, input logic [8:0] a, input logic [8:0] b);
    case (sel)
      4'd0: return a;
      4'd1: return b;
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return a + 9'd1;
      4'd5: return a >> 1;
      default: return 9'h000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      pc <= '0; iar <= '0; idr <= '0; ir <= '0; ac <= '0; mar <= '0; mdr <= '0;
      neg_m <= 1'b0; lsb_m <= 1'b0;
      for (int i = 0; i < 16; i++) rr[i] <= '0;
      for (int i = 0; i < 512; i++) dram[i] <= dram_init[i];
    end else begin
      if (dpi.select_mux_a == 4'd0)      a_v = idr;
      else if (dpi.select_mux_a == 4'd1) a_v = mdr;
      else                               a_v = rr[dpi.select_mux_a];
      b_v   = (dpi.select_mux_b == 2'd1) ? ac : 9'h000;
      res_v = alu_fn(dpi.alu_sel, a_v, b_v);
      if (dpi.inc_pc)     pc <= pc + 9'd1;
      if (dpi.write_pc)   pc <= idr;
      if (dpi.write_iar)  iar <= pc;
      if (dpi.write_idr)  idr <= iram[iar];
      if (dpi.write_ir)   ir <= idr;
      if (dpi.write_ac) begin
        ac    <= res_v;
        lsb_m <= res_v[0];
        neg_m <= (dpi.alu_sel == 4'd3) ? (a_v < b_v) : res_v[8];
      end
      if (dpi.write_mar)  mar <= res_v;
      if (dpi.write2_mdr) mdr <= res_v;
      if (dpi.write1_mdr) mdr <= dram[mar];
      if (dpi.write_dram) dram[mar] <= mdr;
      if (dpi.write_rcol)     rr[2] <= res_v;
      if (dpi.write_rrow)     rr[3] <= res_v;
      if (dpi.write_ri)       rr[4] <= res_v;
      if (dpi.write_rj)       rr[5] <= res_v;
      if (dpi.write_rtotal)   rr[6] <= res_v;
      if (dpi.write_raddress) rr[7] <= res_v;
      if (dpi.write_rbnd)     rr[8] <= res_v;
      if (dpi.write_rcoltemp) rr[9] <= res_v;
    end
  end

  // strobe monitors (cumulative; the sequence takes differences)
  logic [19:0] strb1;
  logic [7:0]  rstrb1;
  logic [11:0] regwr1;
  assign rstrb1 = {dpi.write_rcoltemp, dpi.write_rbnd, dpi.write_raddress, dpi.write_rtotal,
                   dpi.write_rj, dpi.write_ri, dpi.write_rrow, dpi.write_rcol};
  assign regwr1 = {dpi.write_ac, dpi.write_mar, dpi.write1_mdr, dpi.write2_mdr, rstrb1};
  assign strb1  = {dpi.inc_pc, dpi.write_pc, dpi.write_iar, dpi.inc_iar, dpi.write_idr,
                   dpi.write_ir, dpi.write_tr, dpi.write_dram, dpi.write_mar, dpi.write1_mdr,
                   dpi.write2_mdr, dpi.write_ac, rstrb1};

  int c_rcol = 0, c_rwr = 0, c_wpc = 0, c_wdram = 0, c_offlow = 0, c_mdr1 = 0, c_viol = 0;
  int run1 = 0, run2 = 0, last_run1 = 0, last_run2 = 0;

  always @(negedge clk) begin
    if (rst) begin
      run1 = 0;
      run2 = 0;
    end else begin
      if (dpi.write_rcol) c_rcol++;
      if (rstrb1 != 8'h00) c_rwr++;
      if (dpi.write_pc) c_wpc++;
      if (dpi.write_dram) c_wdram++;
      if (dpi.write1_mdr) c_mdr1++;
      if ($countones(regwr1) > 1 || dpi.inc_iar || dpi.write_tr) c_viol++;
      if (!dpi.off_dram) begin c_offlow++; run1++; end else run1 = 0;
      if (dpi.write1_mdr) last_run1 = run1;
      if (!dpi2.off_dram) run2++; else run2 = 0;
      if (dpi2.write1_mdr) last_run2 = run2;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int b_rcol, b_rwr, b_wpc, b_wdram, b_offlow, b_mdr1;
  int n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_prog();
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 512; i++) begin
      iram[i] = 9'h000;
      dram_init[i] = 9'h000;
    end
  endtask

  task automatic end_prog();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b_rcol = c_rcol; b_rwr = c_rwr; b_wpc = c_wpc;
    b_wdram = c_wdram; b_offlow = c_offlow; b_mdr1 = c_mdr1;
  endtask

  task automatic run_prog(output int cyc);
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
    end while (!done && cyc < 400);
    check("reached_done", done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    step = 1'b1;
    begin_prog();
    repeat (2) @(negedge clk);
    check("rst_strobes", strb1, 20'h0);
    check("rst_off_dram", dpi.off_dram, 1'b1);
    check("rst_selects", {dpi.select_mux_a, dpi.select_mux_b, dpi.alu_sel}, 10'h0);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    end_prog();
    repeat (3) @(negedge clk);
    check("idle_no_start", strb1, 20'h0);

    // NOP then HALT
    begin_prog();
    iram[0] = 9'h000; iram[1] = 9'h1F0;
    end_prog();
    run_prog(n);
    check("nop_cycles", n, 9 + 2 * STEP_EXTRA);
    check("nop_illegal", illegal, 1'b0);

    // LDI 5, MOVR 2, HALT
    begin_prog();
    iram[0] = 9'h010; iram[1] = 9'h005; iram[2] = 9'h032; iram[3] = 9'h1F0;
    end_prog();
    run_prog(n);
    check("ldi_movr_cycles", n, 17 + 3 * STEP_EXTRA);
    check("rcol_value", rr[2], 9'h005);
    check("ac_value", ac, 9'h005);
    check("rcol_pulses", c_rcol - b_rcol, 1);
    check("halt_strobes", strb1, 20'h0);
    check("halt_off_dram", dpi.off_dram, 1'b1);

    // Raddress=0x010, LOAD
    begin_prog();
    iram[0] = 9'h010; iram[1] = 9'h010; iram[2] = 9'h037; iram[3] = 9'h080; iram[4] = 9'h1F0;
    dram_init[9'h010] = 9'h0AB;
    end_prog();
    run_prog(n);
    check("load_cycles", n, 25 + 4 * STEP_EXTRA);
    check("load_ac", ac, 9'h0AB);
    check("load_offlow", c_offlow - b_offlow, 3);
    check("load_run_w1", last_run1, 3);
    check("load_mdr_pulses", c_mdr1 - b_mdr1, 1);
    check("load_run_w2", last_run2, 4);

    // AC=3, Raddress=0x020, STORE
    begin_prog();
    iram[0] = 9'h010; iram[1] = 9'h020; iram[2] = 9'h037;
    iram[3] = 9'h010; iram[4] = 9'h003; iram[5] = 9'h090; iram[6] = 9'h1F0;
    end_prog();
    run_prog(n);
    check("store_cycles", n, 31 + 5 * STEP_EXTRA);
    check("store_dram", dram[9'h020], 9'h003);
    check("store_pulses", c_wdram - b_wdram, 1);
    check("store_offlow", c_offlow - b_offlow, 1);

    // SUB 5-7 (neg) then JMPN 0x040
    begin_prog();
    iram[0] = 9'h010; iram[1] = 9'h005; iram[2] = 9'h032; iram[3] = 9'h010; iram[4] = 9'h007;
    iram[5] = 9'h052; iram[6] = 9'h0B0; iram[7] = 9'h040; iram[8] = 9'h1F0; iram[9'h040] = 9'h1F0;
    end_prog();
    run_prog(n);
    check("sub_neg_ac", ac, 9'h1FE);
    check("jmpn_taken_iar", iar, 9'h040);
    check("jmpn_taken_wpc", c_wpc - b_wpc, 1);

    // SUB 5-3 (not neg) then JMPN falls through
    begin_prog();
    iram[0] = 9'h010; iram[1] = 9'h005; iram[2] = 9'h032; iram[3] = 9'h010; iram[4] = 9'h003;
    iram[5] = 9'h052; iram[6] = 9'h0B0; iram[7] = 9'h040; iram[8] = 9'h1F0; iram[9'h040] = 9'h1F0;
    end_prog();
    run_prog(n);
    check("sub_pos_ac", ac, 9'h002);
    check("jmpn_fall_iar", iar, 9'h008);
    check("jmpn_fall_wpc", c_wpc - b_wpc, 0);

    // undefined opcode 0x0D
    begin_prog();
    iram[0] = 9'h0D0;
    end_prog();
    run_prog(n);
    check("op0d_cycles", n, 5 + STEP_EXTRA);
    check("op0d_illegal", illegal, 1'b1);
    check("op0d_rwr", c_rwr - b_rwr, 0);

    // MOVR to read-only register 1
    begin_prog();
    iram[0] = 9'h010; iram[1] = 9'h005; iram[2] = 9'h031;
    end_prog();
    run_prog(n);
    check("movr1_illegal", illegal, 1'b1);
    check("movr1_rwr", c_rwr - b_rwr, 0);

    // reset in the middle of LOAD (L2)
    begin_prog();
    iram[0] = 9'h010; iram[1] = 9'h010; iram[2] = 9'h037; iram[3] = 9'h080; iram[4] = 9'h1F0;
    dram_init[9'h010] = 9'h0AB;
    end_prog();
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!dpi.write1_mdr && n < 100);
    check("reached_l2", dpi.write1_mdr, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_strobes", strb1, 20'h0);
    check("midrst_off_dram", dpi.off_dram, 1'b1);
    check("midrst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle", strb1, 20'h0);
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end while (!dpi.write_iar && n < 10);
    check("restart_f1", n, 1 + STEP_EXTRA);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 400);
    check("restart_done", done, 1'b1);
    check("restart_ac", ac, 9'h0AB);

    check("onehot_and_reserved", c_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
